// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocator and its frequency ROM.
package synth_pkg;

    localparam int unsigned NVOICES   = 8;
    localparam int unsigned FREQ_FRAC = 10;
    localparam int unsigned VOL_SHIFT = 20;
    localparam int unsigned STAMP_W   = 16;

    // A4 = 440 Hz in Q22.10; the synth divides by the frequency, so never 0.
    localparam logic [31:0] FREQ_RESET = 32'd440 << FREQ_FRAC;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        APPLY
    } alloc_state_t;

    typedef struct packed {
        logic [6:0] note;
        logic [6:0] velocity;
        logic       on;
    } note_event_t;

endpackage

// File: rtl/note_freq_rom.sv
// MIDI note -> equal-tempered frequency (A4 = 440 Hz), Hz in Q22.10, rounded.
module note_freq_rom
    import synth_pkg::*;
(
    input  logic [6:0]  i_note,
    output logic [31:0] o_freq
);

    logic [3:0]  w_octave;
    logic [3:0]  w_semi;
    logic [3:0]  w_shift;
    logic [31:0] w_base;

    // Octave 4 (C4..B4) held as Hz * 2^20; octave o scales by 2^(o-5)
    // relative to Q22.10 and the final shift rounds to nearest.
    always_comb begin
        w_octave = 4'(i_note / 7'd12);
        w_semi   = 4'(i_note % 7'd12);
        case (w_semi)
            4'd0:    w_base = 32'd274334289;
            4'd1:    w_base = 32'd290647054;
            4'd2:    w_base = 32'd307929828;
            4'd3:    w_base = 32'd326240288;
            4'd4:    w_base = 32'd345639545;
            4'd5:    w_base = 32'd366192342;
            4'd6:    w_base = 32'd387967272;
            4'd7:    w_base = 32'd411037006;
            4'd8:    w_base = 32'd435478539;
            4'd9:    w_base = 32'd461373440;
            4'd10:   w_base = 32'd488808132;
            4'd11:   w_base = 32'd517874176;
            default: w_base = 32'd274334289;
        endcase
        w_shift = 4'd15 - w_octave;
        o_freq  = (w_base + (32'd1 << (w_shift - 4'd1))) >> w_shift;
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: assigns note events to voices (match, free,
// else steal oldest) and drives the synth's per-voice registered arrays.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned NVOICES   = synth_pkg::NVOICES,
    parameter int unsigned VOL_SHIFT = synth_pkg::VOL_SHIFT,
    parameter int unsigned STAMP_W   = synth_pkg::STAMP_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_note_on,
    input  logic [6:0]                ev_note,
    input  logic [6:0]                ev_velocity,
    input  logic                      all_off,
    output logic [NVOICES-1:0][31:0]  frequencies,
    output logic [NVOICES-1:0][31:0]  voice_volumes,
    output logic [NVOICES-1:0]        voice_active,
    output logic                      steal
);

    localparam int unsigned IDX_W = (NVOICES > 1) ? $clog2(NVOICES) : 1;

    alloc_state_t                     r_state;
    note_event_t                      r_ev;
    logic [IDX_W-1:0]                 r_scan_k;
    logic [NVOICES-1:0][6:0]          r_note;
    logic [NVOICES-1:0][STAMP_W-1:0]  r_stamp;
    logic [STAMP_W-1:0]               r_stamp_ctr;
    logic                             r_match_found;
    logic                             r_free_found;
    logic [IDX_W-1:0]                 r_match_idx;
    logic [IDX_W-1:0]                 r_free_idx;
    logic [IDX_W-1:0]                 r_old_idx;
    logic [STAMP_W-1:0]               r_old_age;

    logic [STAMP_W-1:0]               w_age;
    logic                             w_key_on;
    logic                             w_is_steal;
    logic [IDX_W-1:0]                 w_target;
    logic [31:0]                      w_rom_freq;

    note_freq_rom u_rom (
        .i_note (r_ev.note),
        .o_freq (w_rom_freq)
    );

    // Candidate selection and the modular age of the voice being scanned.
    always_comb begin
        w_age      = r_stamp_ctr - r_stamp[r_scan_k];
        w_key_on   = r_ev.on && (r_ev.velocity != 7'd0);
        w_is_steal = !r_match_found && !r_free_found;
        if (r_match_found)
            w_target = r_match_idx;
        else if (r_free_found)
            w_target = r_free_idx;
        else
            w_target = r_old_idx;
    end

    // Allocator FSM: latch event, scan voices one per cycle, apply result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ev          <= '0;
            r_scan_k      <= '0;
            r_note        <= '0;
            r_stamp       <= '0;
            r_stamp_ctr   <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_match_idx   <= '0;
            r_free_idx    <= '0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
            frequencies   <= {NVOICES{FREQ_RESET}};
            voice_volumes <= '0;
            voice_active  <= '0;
            steal         <= 1'b0;
            ev_ready      <= 1'b1;
        end else if (all_off) begin
            voice_volumes <= '0;
            voice_active  <= '0;
            steal         <= 1'b0;
            ev_ready      <= 1'b1;
            r_state       <= IDLE;
        end else begin
            steal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ev_valid && ev_ready) begin
                        r_ev.note     <= ev_note;
                        r_ev.velocity <= ev_velocity;
                        r_ev.on       <= ev_note_on;
                        ev_ready      <= 1'b0;
                        r_scan_k      <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                        r_old_idx     <= '0;
                        r_old_age     <= '0;
                        r_state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (!r_match_found && voice_active[r_scan_k] &&
                        (r_note[r_scan_k] == r_ev.note)) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_scan_k;
                    end
                    if (!r_free_found && !voice_active[r_scan_k]) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_scan_k;
                    end
                    // Strict compare keeps the lower index on equal ages.
                    if (w_age > r_old_age) begin
                        r_old_age <= w_age;
                        r_old_idx <= r_scan_k;
                    end
                    if (r_scan_k == IDX_W'(NVOICES - 1))
                        r_state <= APPLY;
                    else
                        r_scan_k <= r_scan_k + 1'b1;
                end
                APPLY: begin
                    if (w_key_on) begin
                        frequencies[w_target]   <= w_rom_freq;
                        voice_volumes[w_target] <= 32'(r_ev.velocity) << VOL_SHIFT;
                        voice_active[w_target]  <= 1'b1;
                        r_note[w_target]        <= r_ev.note;
                        r_stamp[w_target]       <= r_stamp_ctr;
                        r_stamp_ctr             <= r_stamp_ctr + 1'b1;
                        steal                   <= w_is_steal;
                    end else if (r_match_found) begin
                        voice_volumes[r_match_idx] <= '0;
                        voice_active[r_match_idx]  <= 1'b0;
                    end
                    ev_ready <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: vector table plus scoreboard,
// with hand-written all_off, mid-scan reset and stamp-wrap sequences.
module tb_voice_allocator;
    import synth_pkg::*;

    localparam int NV         = 8;
    localparam int VS         = 20;
    // Narrow stamp so the age counter wraps within a short run.
    localparam int TB_STAMP_W = 5;
    localparam logic [31:0] F_A4 = 32'd450560;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 ev_valid = 1'b0;
    logic                 ev_ready;
    logic                 ev_note_on = 1'b0;
    logic [6:0]           ev_note = '0;
    logic [6:0]           ev_velocity = '0;
    logic                 all_off = 1'b0;
    logic [NV-1:0][31:0]  frequencies;
    logic [NV-1:0][31:0]  voice_volumes;
    logic [NV-1:0]        voice_active;
    logic                 steal;

    always #5 clk = ~clk;

    voice_allocator #(
        .NVOICES   (NV),
        .VOL_SHIFT (VS),
        .STAMP_W   (TB_STAMP_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_note_on    (ev_note_on),
        .ev_note       (ev_note),
        .ev_velocity   (ev_velocity),
        .all_off       (all_off),
        .frequencies   (frequencies),
        .voice_volumes (voice_volumes),
        .voice_active  (voice_active),
        .steal         (steal)
    );

    typedef struct {
        bit         rst;
        bit         on;
        int         note;
        int         vel;
        int         voice;   // -1: event has no effect
        bit         stl;
        logic [7:0] act;
    } vec_t;

    typedef struct {
        logic [NV-1:0][31:0] freq;
        logic [NV-1:0][31:0] vol;
        logic [NV-1:0]       act;
        logic                stl;
    } exp_t;

    exp_t                sbq[$];
    logic [NV-1:0][31:0] e_freq;
    logic [NV-1:0][31:0] e_vol;
    logic [NV-1:0]       e_act;
    logic [NV-1:0][31:0] s_f;
    logic [NV-1:0][31:0] s_v;
    logic [NV-1:0]       s_a;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] rom_model(input int n);
        real f;
        f = 440.0 * (2.0 ** (real'(n - 69) / 12.0)) * 1024.0;
        return 32'($rtoi(f + 0.5));
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        ev_valid = 1'b0;
        all_off  = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        e_freq = {NV{F_A4}};
        e_vol  = '0;
        e_act  = '0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_freq"},  256'(frequencies),   256'({NV{F_A4}}));
        chk({tag, "_vol"},   256'(voice_volumes), 256'(0));
        chk({tag, "_act"},   256'(voice_active),  256'(0));
        chk({tag, "_steal"}, 256'(steal),         256'(0));
        chk({tag, "_ready"}, 256'(ev_ready),      256'(1));
    endtask

    task automatic model_push(input vec_t v);
        exp_t e;
        if (v.voice >= 0) begin
            if (v.on && v.vel != 0) begin
                e_freq[v.voice] = rom_model(v.note);
                e_vol[v.voice]  = 32'(v.vel) << VS;
            end else begin
                e_vol[v.voice] = '0;
            end
        end
        e_act  = v.act;
        e.freq = e_freq;
        e.vol  = e_vol;
        e.act  = e_act;
        e.stl  = v.stl;
        sbq.push_back(e);
    endtask

    task automatic send(input vec_t v);
        int   n;
        logic same;
        exp_t e;
        n = 0;
        while (!ev_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ready_idle", 256'(ev_ready), 256'(1));
        s_f = frequencies;
        s_v = voice_volumes;
        s_a = voice_active;
        ev_note_on  = v.on;
        ev_note     = 7'(v.note);
        ev_velocity = 7'(v.vel);
        ev_valid    = 1'b1;
        @(posedge clk);
        model_push(v);
        @(negedge clk);
        ev_valid = 1'b0;
        same = 1'b1;
        n    = 1;
        while (!ev_ready && n < 30) begin
            if (frequencies !== s_f || voice_volumes !== s_v ||
                voice_active !== s_a || steal !== 1'b0)
                same = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("latency",    256'(n),    256'(NV + 2));
        chk("quiet_scan", 256'(same), 256'(1));
        e = sbq.pop_front();
        chk("freq",  256'(frequencies),   256'(e.freq));
        chk("vol",   256'(voice_volumes), 256'(e.vol));
        chk("act",   256'(voice_active),  256'(e.act));
        chk("steal", 256'(steal),         256'(e.stl));
        @(negedge clk);
        chk("steal_pulse", 256'(steal), 256'(0));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    vec_t vecs[18];

    initial begin
        //            rst on  note vel voice stl act
        vecs[0]  = '{1, 1, 69, 100, 0, 0, 8'h01};
        vecs[1]  = '{1, 1, 60, 10,  0, 0, 8'h01};
        vecs[2]  = '{0, 1, 61, 11,  1, 0, 8'h03};
        vecs[3]  = '{0, 1, 62, 12,  2, 0, 8'h07};
        vecs[4]  = '{0, 1, 63, 13,  3, 0, 8'h0F};
        vecs[5]  = '{0, 1, 64, 14,  4, 0, 8'h1F};
        vecs[6]  = '{0, 1, 65, 15,  5, 0, 8'h3F};
        vecs[7]  = '{0, 1, 66, 16,  6, 0, 8'h7F};
        vecs[8]  = '{0, 1, 67, 17,  7, 0, 8'hFF};
        vecs[9]  = '{0, 1, 72, 20,  0, 1, 8'hFF};
        vecs[10] = '{1, 1, 60, 50,  0, 0, 8'h01};
        vecs[11] = '{0, 1, 60, 90,  0, 0, 8'h01};
        vecs[12] = '{0, 0, 61, 40, -1, 0, 8'h01};
        vecs[13] = '{0, 1, 64, 70,  1, 0, 8'h03};
        vecs[14] = '{0, 1, 64, 0,   1, 0, 8'h01};
        vecs[15] = '{0, 0, 60, 33,  0, 0, 8'h00};
        vecs[16] = '{0, 1, 62, 5,   0, 0, 8'h01};
        vecs[17] = '{0, 1, 70, 40,  1, 0, 8'h03};

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst) begin
                do_reset();
                check_reset_state("rst");
            end
            send(vecs[i]);
        end

        // all_off in the middle of a note-on scan: event must never land.
        ev_note_on = 1'b1; ev_note = 7'd71; ev_velocity = 7'd60; ev_valid = 1'b1;
        @(negedge clk);
        ev_valid = 1'b0;
        idle_cycles(3);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        e_vol = '0;
        e_act = '0;
        chk("aoff_vol",   256'(voice_volumes), 256'(0));
        chk("aoff_act",   256'(voice_active),  256'(0));
        chk("aoff_ready", 256'(ev_ready),      256'(1));
        chk("aoff_freq",  256'(frequencies),   256'(e_freq));
        idle_cycles(12);
        chk("aoff_noapply_act",  256'(voice_active), 256'(0));
        chk("aoff_noapply_freq", 256'(frequencies),  256'(e_freq));

        // all_off together with a transfer: event consumed and discarded.
        ev_note_on = 1'b1; ev_note = 7'd72; ev_velocity = 7'd10; ev_valid = 1'b1;
        all_off = 1'b1;
        @(negedge clk);
        ev_valid = 1'b0;
        all_off  = 1'b0;
        chk("aoff_xfer_ready", 256'(ev_ready), 256'(1));
        idle_cycles(12);
        chk("aoff_xfer_act", 256'(voice_active),  256'(0));
        chk("aoff_xfer_vol", 256'(voice_volumes), 256'(0));
        send('{0, 1, 73, 10, 0, 0, 8'h01});

        // Reset during a scan drops the pending event.
        ev_note_on = 1'b1; ev_note = 7'd74; ev_velocity = 7'd20; ev_valid = 1'b1;
        @(negedge clk);
        ev_valid = 1'b0;
        idle_cycles(4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("midrst");
        idle_cycles(12);
        chk("midrst_lost", 256'(voice_active), 256'(0));

        // Continuous stealing across the stamp counter wrap: oldest is i%8.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.rst   = 1'b0;
            v.on    = 1'b1;
            v.note  = 20 + i;
            v.vel   = i + 1;
            v.voice = i % NV;
            v.stl   = (i >= NV);
            v.act   = (i >= NV - 1) ? 8'hFF : 8'((1 << (i + 1)) - 1);
            send(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
